// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared types and constants for the byte-wise instruction fetch unit.
//   addr_t / word_t / inst_t : 32-bit byte address, data word, instruction word
//   bcnt_t                   : byte counter; one extra bit so that "all four
//                              addresses issued" (count 4) is representable
//   NOP_INST                 : instruction presented out of reset
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [31:0] inst_t;
    typedef logic [2:0]  bcnt_t;

    localparam inst_t NOP_INST       = 32'h0000_0013;
    localparam int    BYTES_PER_INST = 4;
    localparam addr_t INST_STRIDE    = 32'd4;

    // Byte address of byte k of the instruction at base (wraps at 2^32).
    function automatic addr_t byte_addr(input addr_t base, input bcnt_t k);
        return base + addr_t'(k);
    endfunction

endpackage

// File: rtl/inst_fetch_assembler.sv
// -----------------------------------------------------------------------------
// inst_assembler
// Byte-merging datapath: byte counter, one-cycle read-return tracker and four
// byte registers, each with its own write enable.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : global enable; all state holds while low
//   clr_i      : restart a fetch (counter to 0, partial bytes discarded,
//                any in-flight return ignored)
//   issue_i    : the address for byte cnt_o is on the bus this cycle
//   din_i      : read byte, returned one cycle after its address
//   cnt_o      : index of the next byte address to issue (0..4)
//   last_o     : byte 3 is being returned this cycle
//   word_o     : assembled little-endian word, with the byte returning this
//                cycle already merged in
// -----------------------------------------------------------------------------
module inst_assembler
    import inst_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       issue_i,
    input  logic [7:0] din_i,
    output bcnt_t      cnt_o,
    output logic       last_o,
    output word_t      word_o
);

    bcnt_t      cnt_q, cnt_d;
    logic       cap_vld_q, cap_vld_d;   // a byte returns this cycle
    logic [1:0] cap_idx_q, cap_idx_d;   // which byte it is

    always_comb begin
        cnt_d     = cnt_q;
        cap_vld_d = cap_vld_q;
        cap_idx_d = cap_idx_q;
        if (clr_i) begin
            cnt_d     = '0;
            cap_vld_d = 1'b0;
            cap_idx_d = '0;
        end else begin
            cnt_d     = issue_i ? cnt_q + 3'd1 : cnt_q;
            // Return tracking follows the bus, not the counter: a grant gap
            // simply produces a cycle with nothing to capture.
            cap_vld_d = issue_i;
            cap_idx_d = cnt_q[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
        end else if (en_i) begin
            cnt_q     <= cnt_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_INST; gi++) begin : g_byte
            logic [7:0] byte_q;
            logic       sel;
            logic       wr_en;

            assign sel   = cap_vld_q && (cap_idx_q == 2'(gi));
            assign wr_en = en_i && !clr_i && sel;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    byte_q <= '0;
                end else if (en_i && clr_i) begin
                    byte_q <= '0;
                end else if (wr_en) begin
                    byte_q <= din_i;
                end
            end

            // Bypass the returning byte so the full word is usable in the
            // same cycle the last byte arrives.
            assign word_o[8*gi +: 8] = sel ? din_i : byte_q;
        end
    endgenerate

    assign cnt_o  = cnt_q;
    assign last_o = cap_vld_q && (cap_idx_q == 2'd3);

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Fetches 32-bit instructions one byte at a time over an 8-bit memory bus.
//   clk, rst_n : clock, asynchronous active-low reset
//   rdy        : global enable; all state and outputs hold while low
//   jump_en    : one-cycle redirect to jump_addr (highest priority)
//   jump_addr  : redirect target pc (no alignment check)
//   stall      : decoder cannot accept an instruction
//   mem_req    : bus request (WAIT_GRANT and READ)
//   mem_grant  : bus owned this cycle
//   mem_addr   : byte address, fetch_pc + byte counter
//   mem_din    : read byte, returned one cycle after its address
//   hit        : pc/inst valid this cycle (one cycle per instruction)
//   pc, inst   : address and assembled instruction
// The first byte address goes out in the WAIT_GRANT cycle the grant arrives,
// so hit follows the first granted address by exactly five cycles.
// -----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic       jump_en,
    input  addr_t      jump_addr,
    input  logic       stall,
    output logic       mem_req,
    input  logic       mem_grant,
    output addr_t      mem_addr,
    input  logic [7:0] mem_din,
    output logic       hit,
    output addr_t      pc,
    output inst_t      inst
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_GRANT = 2'd1,
        READ       = 2'd2,
        VALID      = 2'd3
    } state_t;

    state_t state_q, state_d;
    addr_t  fetch_pc_q, fetch_pc_d;
    addr_t  pc_q, pc_d;
    inst_t  inst_q, inst_d;

    logic   asm_clr, asm_issue, asm_last;
    bcnt_t  asm_cnt;
    word_t  asm_word;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        hit        = 1'b0;
        asm_clr    = 1'b0;
        asm_issue  = 1'b0;
        mem_req    = (state_q == WAIT_GRANT) || (state_q == READ);

        if (rdy) begin
            if (jump_en) begin
                // Redirect wins over everything, including a pending hit.
                fetch_pc_d = jump_addr;
                asm_clr    = 1'b1;
                state_d    = WAIT_GRANT;
            end else begin
                unique case (state_q)
                    IDLE: state_d = WAIT_GRANT;
                    WAIT_GRANT: begin
                        if (mem_grant) begin
                            asm_issue = 1'b1;
                            state_d   = READ;
                        end
                    end
                    READ: begin
                        asm_issue = mem_grant && !asm_cnt[2];
                        if (asm_last) begin
                            pc_d    = fetch_pc_q;
                            inst_d  = asm_word;
                            state_d = VALID;
                        end
                    end
                    VALID: begin
                        if (!stall) begin
                            hit        = 1'b1;
                            fetch_pc_d = fetch_pc_q + INST_STRIDE;
                            asm_clr    = 1'b1;
                            state_d    = WAIT_GRANT;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            pc_q       <= '0;
            inst_q     <= NOP_INST;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
        end
    end

    inst_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (rdy),
        .clr_i   (asm_clr),
        .issue_i (asm_issue),
        .din_i   (mem_din),
        .cnt_o   (asm_cnt),
        .last_o  (asm_last),
        .word_o  (asm_word)
    );

    assign mem_addr = byte_addr(fetch_pc_q, asm_cnt);
    assign pc       = pc_q;
    assign inst     = inst_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL be sampled on the rising edge of clk.
REQ-002 The port clk SHALL be an input, 1 bit wide, and SHALL be the system clock.
REQ-003 The port rst_n SHALL be an input, 1 bit wide: the asynchronous, active-low reset.
REQ-004 The port rdy SHALL be an input, 1 bit wide: global enable; while low, all state and outputs SHALL hold.
REQ-005 The port jump_en SHALL be an input, 1 bit wide: redirect request, valid for one cycle.
REQ-006 The port jump_addr SHALL be an input, 32 bits wide: the redirect target pc.
REQ-007 The port stall SHALL be an input, 1 bit wide: the downstream decoder cannot accept an instruction.
REQ-008 The port mem_req SHALL be an output, 1 bit wide: instruction-memory bus request.
REQ-009 The port mem_grant SHALL be an input, 1 bit wide: the bus is owned this cycle.
REQ-010 The port mem_addr SHALL be an output, 32 bits wide: byte address driven while granted.
REQ-011 The port mem_din SHALL be an input, 8 bits wide: the read byte, returned one cycle after its address.
REQ-012 The port hit SHALL be an output, 1 bit wide: pc and inst are valid this cycle.
REQ-013 The port pc SHALL be an output, 32 bits wide: the address of inst.
REQ-014 The port inst SHALL be an output, 32 bits wide: the assembled instruction word.

Function
REQ-015 The FSM SHALL have exactly four states, IDLE, WAIT_GRANT, READ and VALID, and SHALL leave IDLE for WAIT_GRANT on the first cycle that rdy=1 after reset.
REQ-016 In WAIT_GRANT the block SHALL assert mem_req=1, SHALL remain in WAIT_GRANT until mem_grant=1, and SHALL then enter READ.
REQ-017 In READ the block SHALL drive mem_addr = fetch_pc + k, where k is a 3-bit byte counter running 0..3, and SHALL capture mem_din one cycle later into byte k, little-endian (byte 0 is inst[7:0]).
REQ-018 After the fourth byte is captured, the block SHALL drop mem_req and enter VALID; the latency from the first granted address to hit SHALL be exactly 5 cycles when stall=0.
REQ-019 If mem_grant drops during READ, the block SHALL freeze the counter and address, and SHALL resume when the grant returns, without re-reading bytes already captured.
REQ-020 In VALID with stall=0, the block SHALL assert hit for exactly one cycle, set fetch_pc to fetch_pc+4 (32-bit wrap-around, so 32'hFFFFFFFC wraps to 0), and enter WAIT_GRANT.
REQ-021 In VALID with stall=1, hit SHALL stay 0 and pc/inst SHALL be held unchanged until stall=0.
REQ-022 jump_en=1 SHALL take priority over every other event: in that cycle the block SHALL set hit=0, load fetch_pc with jump_addr, discard any partial bytes, reset the counter, and enter WAIT_GRANT.
REQ-023 A jump arriving simultaneously with a VALID/stall=0 cycle SHALL suppress the hit; the pending instruction SHALL be lost.
REQ-024 A byte returning on the cycle after a jump SHALL be ignored.
REQ-025 hit SHALL never be asserted while stall=1 or rdy=0.
REQ-026 The block SHALL NOT check jump_addr alignment; a misaligned target SHALL be fetched byte-wise as given.

Reset
REQ-027 While rst_n=0 (asynchronous), the block SHALL force state=IDLE, fetch_pc=32'h0, pc=32'h0, inst=32'h00000013 (NOP), hit=0, mem_req=0, mem_addr=32'h0 and byte counter=0.
REQ-028 Reset asserted mid-READ SHALL abandon the fetch, and the block SHALL restart at pc 0 after rst_n rises.

Structure
REQ-029 The types addr_t, inst_t and word_t and the NOP encoding SHALL come from the shared defines header.
REQ-030 The FSM state encodings SHALL be local to inst_fetch.
REQ-031 The byte-merging datapath (four 8-bit registers, each with its own write enable, plus the counter) SHALL be one sub-module, inst_assembler.

Verification
REQ-032 Reset then continuous grant, memory bytes 0..3 = 13 05 10 00 -> hit at cycle 5 after the first address, pc=0, inst=32'h00100513; next fetch addr=4.
REQ-033 Grant withheld 3 cycles, then given -> mem_req held high throughout; hit exactly 5 cycles after the grant.
REQ-034 stall=1 for 4 cycles when VALID is reached -> hit=0 and inst stable; hit=1 on the first cycle stall=0; pc advances by 4.
REQ-035 jump_en with jump_addr=32'h1000 during the READ of byte 2 -> no hit; next mem_addr=32'h1000; the returned word is reported with pc=32'h1000.
REQ-036 rdy=0 for 2 cycles mid-READ -> all outputs frozen; inst after resume identical to an uninterrupted run.
REQ-037 rst_n pulsed low mid-READ -> outputs immediately at reset values; the fetch restarts at address 0.
